// File: rtl/mem_responder.sv
// Single-port word memory behind a request/ready handshake. Each accepted request
// completes with a one-cycle mem_ready pulse a fixed LATENCY cycles later.
module mem_responder #(
    parameter int LATENCY   = 4,
    parameter int ADDR_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        mem_req,
    input  logic [31:0] mem_addr,
    input  logic        mem_write_en,
    input  logic [7:0]  mem_data_in  [0:3],
    output logic [7:0]  mem_data_out [0:3],
    output logic        mem_ready,
    output logic        mem_busy
);
    localparam int IDX_W = ADDR_BITS - 2;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic [IDX_W-1:0] cap_idx;
    logic             cap_we;
    logic [31:0]      cap_word;
    logic [31:0]      storage [DEPTH];

    logic [IDX_W-1:0] resp_idx;
    logic             resp_we;
    logic [31:0]      resp_wr_word;
    logic [31:0]      resp_word;
    logic             enter_resp;
    logic             unused_addr_bits;

    // Lane k sits in bits [8k+7:8k] of the stored word.
    function automatic logic [31:0] pack_lanes(input logic [7:0] lanes [0:3]);
        return {lanes[3], lanes[2], lanes[1], lanes[0]};
    endfunction

    assign unused_addr_bits = ^{mem_addr[31:ADDR_BITS], mem_addr[1:0]};

    // With LATENCY=1 the response is formed on the accepting edge, straight from the inputs.
    always_comb begin
        if (state == IDLE) begin
            resp_idx     = mem_addr[ADDR_BITS-1:2];
            resp_we      = mem_write_en;
            resp_wr_word = pack_lanes(mem_data_in);
        end else begin
            resp_idx     = cap_idx;
            resp_we      = cap_we;
            resp_wr_word = cap_word;
        end
        resp_word  = resp_we ? resp_wr_word : storage[resp_idx];
        enter_resp = ((state == IDLE) && mem_req && (LATENCY == 1)) ||
                     ((state == BUSY) && (cnt == 4'd0));
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            mem_ready <= 1'b0;
            mem_busy  <= 1'b0;
            for (int k = 0; k < 4; k++) mem_data_out[k] <= 8'h00;
        end else begin
            mem_ready <= enter_resp;
            if (enter_resp) begin
                for (int k = 0; k < 4; k++) mem_data_out[k] <= resp_word[8*k +: 8];
            end
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        cap_idx  <= mem_addr[ADDR_BITS-1:2];
                        cap_we   <= mem_write_en;
                        cap_word <= pack_lanes(mem_data_in);
                        mem_busy <= 1'b1;
                        cnt      <= CNT_LOAD;
                        state    <= (LATENCY == 1) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) state <= RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                RESP: begin
                    state    <= IDLE;
                    mem_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The write commits as RESP is left, so a reset during RESP still drops it.
    always_ff @(posedge clk) begin
        if (rst_b && (state == RESP) && cap_we) storage[cap_idx] <= cap_word;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a LATENCY=4 and a LATENCY=1 instance checked each cycle
// against a transaction-level model, plus directed literal expectations.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst_b;
    logic        req0, we0, rdy0, busy0;
    logic [31:0] addr0, din0, dout0_w;
    logic [7:0]  din0_u [0:3];
    logic [7:0]  dout0_u [0:3];
    logic        req1, we1, rdy1, busy1;
    logic [31:0] addr1, din1, dout1_w;
    logic [7:0]  din1_u [0:3];
    logic [7:0]  dout1_u [0:3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign din0_u  = '{din0[7:0], din0[15:8], din0[23:16], din0[31:24]};
    assign din1_u  = '{din1[7:0], din1[15:8], din1[23:16], din1[31:24]};
    assign dout0_w = {dout0_u[3], dout0_u[2], dout0_u[1], dout0_u[0]};
    assign dout1_w = {dout1_u[3], dout1_u[2], dout1_u[1], dout1_u[0]};

    mem_responder #(.LATENCY(4), .ADDR_BITS(16)) dut0 (
        .clk(clk), .rst_b(rst_b), .mem_req(req0), .mem_addr(addr0),
        .mem_write_en(we0), .mem_data_in(din0_u), .mem_data_out(dout0_u),
        .mem_ready(rdy0), .mem_busy(busy0)
    );

    mem_responder #(.LATENCY(1), .ADDR_BITS(16)) dut1 (
        .clk(clk), .rst_b(rst_b), .mem_req(req1), .mem_addr(addr1),
        .mem_write_en(we1), .mem_data_in(din1_u), .mem_data_out(dout1_u),
        .mem_ready(rdy1), .mem_busy(busy1)
    );

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endfunction

    // Transaction model: one outstanding request per instance, ready at age L-1, retire at age L.
    int          cyc = 0;
    bit          started = 0;
    logic        m_rdy [2], m_busy [2], m_have [2], m_we [2];
    logic [31:0] m_data [2], m_wd [2];
    int          m_acc [2], m_key [2];
    logic [31:0] mdl_mem [int];

    function automatic logic [31:0] mread(input int key);
        if (mdl_mem.exists(key)) return mdl_mem[key];
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        int          lat;
        logic        r, w;
        logic [31:0] a, d;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            lat = (i == 0) ? 4 : 1;
            r   = (i == 0) ? req0 : req1;
            w   = (i == 0) ? we0 : we1;
            a   = (i == 0) ? addr0 : addr1;
            d   = (i == 0) ? din0 : din1;
            m_rdy[i] = 1'b0;
            if (!rst_b) begin
                m_have[i] = 1'b0;
                m_busy[i] = 1'b0;
                m_data[i] = 32'h0;
            end else begin
                if (m_have[i] && (cyc - m_acc[i] == lat)) begin
                    m_have[i] = 1'b0;
                    m_busy[i] = 1'b0;
                    if (m_we[i]) mdl_mem[m_key[i]] = m_wd[i];
                end else if (!m_have[i] && r) begin
                    m_have[i] = 1'b1;
                    m_busy[i] = 1'b1;
                    m_acc[i]  = cyc;
                    m_key[i]  = i * 65536 + int'(a[15:2]);
                    m_we[i]   = w;
                    m_wd[i]   = d;
                end
                if (m_have[i] && (cyc - m_acc[i] == lat - 1)) begin
                    m_rdy[i]  = 1'b1;
                    m_data[i] = m_we[i] ? m_wd[i] : mread(m_key[i]);
                end
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("ready0", 32'(rdy0), 32'(m_rdy[0]));
            check("busy0", 32'(busy0), 32'(m_busy[0]));
            check("data0", dout0_w, m_data[0]);
            check("ready1", 32'(rdy1), 32'(m_rdy[1]));
            check("busy1", 32'(busy1), 32'(m_busy[1]));
            check("data1", dout1_w, m_data[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run0(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int n, output logic [31:0] q);
        req0 = 1'b1; we0 = w; addr0 = a; din0 = d;
        tick();
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; din0 = 32'h0;
        n = 0;
        while (!rdy0 && n < 20) begin
            tick();
            n++;
        end
        check("ready0 arrives", 32'(rdy0), 32'd1);
        q = dout0_w;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [31:0] q;
        logic [31:0] rq [$];
        rst_b = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; din0 = 32'h0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; din1 = 32'h0;
        tick();
        tick();
        check("reset dout0", dout0_w, 32'h0);
        check("reset dout1", dout1_w, 32'h0);
        rst_b = 1'b1;

        // Preload word 0x10 with lanes {AA,BB,CC,DD}, then read it back.
        run0(1'b1, 32'h10, 32'hDDCCBBAA, n, q);
        check("write echo 0x10", q, 32'hDDCCBBAA);
        run0(1'b0, 32'h10, 32'h0, n, q);
        check("read 0x10 latency", n, 3);
        check("read 0x10 data", q, 32'hDDCCBBAA);

        // Sub-word address selects the whole word; neighbour untouched.
        run0(1'b1, 32'h23, 32'h44332211, n, q);
        run0(1'b0, 32'h20, 32'h0, n, q);
        check("read 0x20 after write 0x23", q, 32'h44332211);
        run0(1'b0, 32'h24, 32'h0, n, q);
        check("read 0x24 unchanged", q, 32'h0);

        // Inputs wiggled during BUSY must be ignored.
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        tick();
        we0 = 1'b1; addr0 = 32'h40; din0 = 32'hFFFFFFFF;
        tick();
        tick();
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; din0 = 32'h0;
        n = 0;
        while (!rdy0 && n < 20) begin
            tick();
            n++;
        end
        check("busy-ignore latency", n, 1);
        check("busy-ignore data", dout0_w, 32'hDDCCBBAA);
        tick();
        run0(1'b0, 32'h40, 32'h0, n, q);
        check("word 0x40 unchanged", q, 32'h0);

        // Reset during a write aborts it; a request held through reset is taken afterwards.
        run0(1'b1, 32'h8, 32'h12345678, n, q);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; din0 = 32'hCAFEF00D;
        tick();
        req0 = 1'b0;
        tick();
        rst_b = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 32'h8; din0 = 32'h0;
        tick();
        check("mid-reset dout0", dout0_w, 32'h0);
        check("mid-reset ready0", 32'(rdy0), 32'd0);
        check("mid-reset busy0", 32'(busy0), 32'd0);
        rst_b = 1'b1;
        tick();
        req0 = 1'b0; addr0 = 32'h0;
        n = 0;
        while (!rdy0 && n < 20) begin
            tick();
            n++;
        end
        check("post-reset latency", n, 3);
        check("word 0x8 keeps old value", dout0_w, 32'h12345678);
        tick();

        // Addresses above ADDR_BITS alias.
        run0(1'b1, 32'h0001_0004, 32'h5AA5C33C, n, q);
        run0(1'b0, 32'h0000_0004, 32'h0, n, q);
        check("wrap read 0x4", q, 32'h5AA5C33C);

        // LATENCY=1 with mem_req held high: accepted every second edge.
        req1 = 1'b1; we1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            addr1 = 32'h100 + 32'(4 * k);
            din1  = 32'hA0B0C000 + 32'(k);
            tick();
        end
        req1 = 1'b0; we1 = 1'b0;
        tick();
        req1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            addr1 = 32'h100 + 32'(4 * k);
            tick();
            if (rdy1) rq.push_back(dout1_w);
        end
        req1 = 1'b0;
        check("b2b ready count", rq.size(), 4);
        for (int j = 0; j < 4; j++) begin
            check("b2b read data", (j < rq.size()) ? rq[j] : 32'hDEADDEAD,
                  32'hA0B0C000 + 32'(2 * j));
        end
        tick();
        req1 = 1'b1; addr1 = 32'h104;
        tick();
        req1 = 1'b0;
        check("b2b skipped word ready", 32'(rdy1), 32'd1);
        check("b2b skipped word 0x104", dout1_w, 32'h0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
